// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer for a 2^ADDR_W-word instruction memory.
//
// Generates the word-index fetch address, absorbs the memory's one-cycle
// registered read latency, and hands instructions plus their word PC to
// decode over a valid/ready handshake. Handles branch/jump redirects, which
// flush stale fetches, and a halt request that stops new fetches.
//
// Ports:
//   clk             system clock, all state updates on posedge
//   rst             synchronous active-high reset
//   mem_addr        word index to instruction memory ({zeros, fetch_pc})
//   mem_inst        memory data, valid the cycle after mem_addr was sampled
//   redirect_valid  one-cycle pulse: branch/jump taken
//   redirect_pc     target word index (only [ADDR_W-1:0] used)
//   halt_req        level: stop issuing new fetches
//   inst_valid      inst_out/inst_pc hold a valid instruction
//   inst_ready      decode accepts (transfer on inst_valid & inst_ready)
//   inst_out        instruction word
//   inst_pc         word index of inst_out, zero-extended
//   halted          halt_req asserted and no fetch in flight (1-cycle lag)
//   fetch_count     transfer counter (only when FETCH_CNT_EN is defined)
//
// Optional feature macro: FETCH_CNT_EN adds the fetch_count output.

module fetch_ctrl #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned RESET_PC = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        halted
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam logic [ADDR_W-1:0] RESET_IDX = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pending;

    logic              skid_full;
    logic [31:0]       skid_inst;
    logic [ADDR_W-1:0] skid_pc;

    logic [ADDR_W-1:0] out_pc;

    logic              issue;
    logic              out_free;
    logic              xfer;

    // Upper target bits are ignored by design.
    logic              unused_redirect_hi;
    assign unused_redirect_hi = ^redirect_pc[31:ADDR_W];

    assign mem_addr = 32'(fetch_pc);
    assign inst_pc  = 32'(out_pc);

    // Output register can take new data when empty or being drained now.
    assign out_free = ~inst_valid | inst_ready;
    assign xfer     = inst_valid & inst_ready;

    // Holding off issue while the output is stalled with a response landing
    // guarantees the single skid entry is never overrun.
    assign issue = ~halt_req & ~redirect_valid & ~skid_full &
                   ~(pending & inst_valid & ~inst_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_IDX;
            pending    <= 1'b0;
            pend_pc    <= '0;
            skid_full  <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            out_pc     <= '0;
            halted     <= 1'b0;
        end else begin
            halted <= halt_req & ~pending;

            if (redirect_valid) begin
                // Flush everything in flight; any pending response is dropped.
                fetch_pc   <= redirect_pc[ADDR_W-1:0];
                pending    <= 1'b0;
                skid_full  <= 1'b0;
                inst_valid <= 1'b0;
            end else begin
                pending <= issue;
                if (issue) begin
                    pend_pc  <= fetch_pc;
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                end

                // Skid is always older than any new response, so it goes first.
                // While the skid is full no fetch is pending (issue is blocked).
                if (skid_full && out_free) begin
                    inst_valid <= 1'b1;
                    inst_out   <= skid_inst;
                    out_pc     <= skid_pc;
                    skid_full  <= 1'b0;
                end else if (pending && out_free) begin
                    inst_valid <= 1'b1;
                    inst_out   <= mem_inst;
                    out_pc     <= pend_pc;
                end else if (pending) begin
                    skid_full  <= 1'b1;
                    skid_inst  <= mem_inst;
                    skid_pc    <= pend_pc;
                end else if (out_free) begin
                    inst_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (xfer) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// A registered memory model holds mem[i] = i + 0x100. Inputs change 1 time
// unit after each rising edge; outputs are sampled at the same point.

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        halted;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] mem [128];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_inst <= mem[mem_addr[6:0]];

    fetch_ctrl #(.ADDR_W(7), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .halted         (halted)
`ifdef FETCH_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        inst_ready     = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Steps until inst_valid is seen, within a fixed cycle budget.
    task automatic wait_valid(output bit ok);
        for (int n = 0; n < 20 && inst_valid !== 1'b1; n++) step();
        ok = (inst_valid === 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        vectors++; if (inst_out !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h want 0", inst_out); end
        vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
`ifdef FETCH_CNT_EN
        vectors++; if (fetch_count !== 32'h0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
`endif
    endtask

    task automatic test_stream_stall();
        bit ok;
        do_reset();
        inst_ready = 1'b1;
        step();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL first_latency: got valid %b want 0", inst_valid); end
        vectors++; if (mem_addr !== 32'd1) begin miscompares++; $display("FAIL first_addr: got %h want 1", mem_addr); end
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid k=%0d: got %b want 1", k, inst_valid); end
            vectors++; if (inst_pc !== 32'(k)) begin miscompares++; $display("FAIL stream_pc: got %0d want %0d", inst_pc, k); end
            vectors++; if (inst_out !== 32'(k + 'h100)) begin miscompares++; $display("FAIL stream_inst: got %h want %h", inst_out, k + 'h100); end
        end
        inst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid c=%0d: got %b want 1", c, inst_valid); end
            vectors++; if (inst_pc !== 32'd3) begin miscompares++; $display("FAIL stall_pc c=%0d: got %0d want 3", c, inst_pc); end
            vectors++; if (inst_out !== 32'h103) begin miscompares++; $display("FAIL stall_inst c=%0d: got %h want 103", c, inst_out); end
            vectors++; if (mem_addr !== 32'd5) begin miscompares++; $display("FAIL stall_addr c=%0d: got %0d want 5", c, mem_addr); end
        end
        inst_ready = 1'b1;
        for (int k = 3; k < 7; k++) begin
            wait_valid(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL resume_timeout: got no valid want pc %0d", k); end
            vectors++; if (inst_pc !== 32'(k)) begin miscompares++; $display("FAIL resume_pc: got %0d want %0d", inst_pc, k); end
            vectors++; if (inst_out !== 32'(k + 'h100)) begin miscompares++; $display("FAIL resume_inst: got %h want %h", inst_out, k + 'h100); end
            step();
        end
    endtask

    task automatic test_redirect();
        int unsigned seq [4] = '{126, 127, 0, 1};
        do_reset();
        inst_ready = 1'b1;
        step();
        for (int k = 0; k < 5; k++) step();
        vectors++; if (inst_pc !== 32'd4) begin miscompares++; $display("FAIL redir_pre_pc: got %0d want 4", inst_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'd40;
        step();
        redirect_valid = 1'b0;
        vectors++; if (mem_addr !== 32'd40) begin miscompares++; $display("FAIL redir_addr: got %0d want 40", mem_addr); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush1: got %b want 0", inst_valid); end
        step();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush2: got %b want 0", inst_valid); end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'd40) begin miscompares++; $display("FAIL redir_target: got v=%b pc=%0d want v=1 pc=40", inst_valid, inst_pc); end
        vectors++; if (inst_out !== 32'h128) begin miscompares++; $display("FAIL redir_inst: got %h want 128", inst_out); end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'd41) begin miscompares++; $display("FAIL redir_next: got v=%b pc=%0d want v=1 pc=41", inst_valid, inst_pc); end

        redirect_valid = 1'b1; redirect_pc = 32'd126;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'(seq[i])) begin miscompares++; $display("FAIL wrap_pc i=%0d: got v=%b pc=%0d want pc=%0d", i, inst_valid, inst_pc, seq[i]); end
            vectors++; if (inst_out !== 32'(seq[i] + 'h100)) begin miscompares++; $display("FAIL wrap_inst i=%0d: got %h want %h", i, inst_out, seq[i] + 'h100); end
            step();
        end

        redirect_valid = 1'b1; redirect_pc = 32'h0000_00C5;
        step();
        redirect_valid = 1'b0;
        vectors++; if (mem_addr !== 32'h45) begin miscompares++; $display("FAIL redir_hi_addr: got %h want 45", mem_addr); end
        step();
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h45) begin miscompares++; $display("FAIL redir_hi_pc: got v=%b pc=%h want pc=45", inst_valid, inst_pc); end
        vectors++; if (inst_out !== 32'h145) begin miscompares++; $display("FAIL redir_hi_inst: got %h want 145", inst_out); end
    endtask

    task automatic test_halt();
        do_reset();
        inst_ready = 1'b1;
        step();
        for (int k = 0; k < 11; k++) step();
        vectors++; if (inst_pc !== 32'd10) begin miscompares++; $display("FAIL halt_pre_pc: got %0d want 10", inst_pc); end
        halt_req = 1'b1;
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'd11) begin miscompares++; $display("FAIL halt_drain: got v=%b pc=%0d want pc=11", inst_valid, inst_pc); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_lag: got %b want 0", halted); end
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL halt_empty c=%0d: got %b want 0", c, inst_valid); end
            vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag c=%0d: got %b want 1", c, halted); end
            vectors++; if (mem_addr !== 32'd12) begin miscompares++; $display("FAIL halt_frozen c=%0d: got %0d want 12", c, mem_addr); end
        end
        halt_req = 1'b0;
        step();
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL release_flag: got %b want 0", halted); end
        vectors++; if (mem_addr !== 32'd13) begin miscompares++; $display("FAIL release_addr: got %0d want 13", mem_addr); end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'd12) begin miscompares++; $display("FAIL release_pc: got v=%b pc=%0d want pc=12", inst_valid, inst_pc); end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'd13) begin miscompares++; $display("FAIL release_next: got v=%b pc=%0d want pc=13", inst_valid, inst_pc); end

        halt_req = 1'b1;
        for (int c = 0; c < 4; c++) step();
        vectors++; if (halted !== 1'b1 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL halt2: got h=%b v=%b want h=1 v=0", halted, inst_valid); end
        vectors++; if (mem_addr !== 32'd15) begin miscompares++; $display("FAIL halt2_addr: got %0d want 15", mem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'd20;
        step();
        redirect_valid = 1'b0;
        vectors++; if (mem_addr !== 32'd20) begin miscompares++; $display("FAIL halt_redir_addr: got %0d want 20", mem_addr); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_redir_flag: got %b want 1", halted); end
        step();
        vectors++; if (mem_addr !== 32'd20 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL halt_redir_noissue: got addr=%0d v=%b want addr=20 v=0", mem_addr, inst_valid); end
        halt_req = 1'b0;
        step();
        vectors++; if (mem_addr !== 32'd21) begin miscompares++; $display("FAIL halt_redir_resume: got %0d want 21", mem_addr); end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'd20 || inst_out !== 32'h114) begin miscompares++; $display("FAIL halt_redir_target: got v=%b pc=%0d inst=%h want pc=20 inst=114", inst_valid, inst_pc, inst_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_ready = 1'b1;
        step(); step(); step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'd1) begin miscompares++; $display("FAIL midrst_pre: got v=%b pc=%0d want pc=1", inst_valid, inst_pc); end
        rst = 1'b1;
        step();
        vectors++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin miscompares++; $display("FAIL midrst_out: got v=%b inst=%h pc=%0d want 0", inst_valid, inst_out, inst_pc); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL midrst_addr: got %0d want 0", mem_addr); end
        rst = 1'b0;
        step();
        vectors++; if (inst_valid !== 1'b0 || mem_addr !== 32'd1) begin miscompares++; $display("FAIL midrst_issue: got v=%b addr=%0d want v=0 addr=1", inst_valid, mem_addr); end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst_out !== 32'h100) begin miscompares++; $display("FAIL midrst_restart: got v=%b pc=%0d inst=%h want pc=0 inst=100", inst_valid, inst_pc, inst_out); end
    endtask

`ifdef FETCH_CNT_EN
    task automatic test_count();
        bit ok;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_valid(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL count_timeout_a: got no valid want valid"); end
            step();
        end
        inst_ready = 1'b0;
        step(); step(); step();
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL count_timeout_b: got no valid want valid"); end
            step();
        end
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL count_timeout_c: got no valid want valid"); end
        redirect_valid = 1'b1; redirect_pc = 32'd50;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL count_timeout_d: got no valid want valid"); end
            step();
        end
        inst_ready = 1'b0;
        vectors++; if (fetch_count !== 32'd20) begin miscompares++; $display("FAIL count_total: got %0d want 20", fetch_count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (fetch_count !== 32'd0 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL count_reset: got cnt=%0d v=%b want 0", fetch_count, inst_valid); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i + 'h100);
        test_reset();
        test_stream_stall();
        test_redirect();
        test_halt();
        test_reset_mid();
`ifdef FETCH_CNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
